// File: rtl/bbus_master.sv
`default_nettype none
// ============================================================================
// bbus_master : sequences single B-bus read/write cycles with ordered
//               pad / level-shifter turnaround. Option: BBUS_MASTER_KEEP_PA_EN
// Revision    : 1.0
// ============================================================================
module bbus_master #(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       pard_n,
  output logic       pawr_n,
  output logic       lvl_pa_dir,
  output logic       lvl_pd_dir,
  input  logic [7:0] pa_in,
  input  logic [7:0] pd_in,
  output logic [7:0] pa_out,
  output logic [7:0] pd_out,
  output logic       pa_dir,
  output logic       pd_dir
);

  localparam logic DIR_INPUT      = 1'b0;
  localparam logic DIR_OUTPUT     = 1'b1;
  localparam logic LVL_DIR_INPUT  = 1'b0;
  localparam logic LVL_DIR_OUTPUT = 1'b1;

  localparam logic [3:0] C_SETUP_LAST  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] C_STROBE_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] C_HOLD_LAST   = 4'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TURN_OUT, S_SETUP, S_STROBE, S_HOLD, S_TURN_IN, S_RELEASE
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       wr_q, wr_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d, rbuf_q, rbuf_d;
  logic       pard_n_q, pard_n_d, pawr_n_q, pawr_n_d;
  logic       lvl_pa_dir_q, lvl_pa_dir_d, lvl_pd_dir_q, lvl_pd_dir_d;
  logic       pa_dir_q, pa_dir_d, pd_dir_q, pd_dir_d;
  logic [7:0] pa_out_q, pa_out_d, pd_out_q, pd_out_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       w_drive, w_span;

  // PA is observed only through the shifter; the pad input is not needed here.
  logic unused_pa_in;
  assign unused_pa_in = ^pa_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    unique case (state_q)
      S_IDLE: if (req_valid) begin
        state_d = S_TURN_OUT;
        wr_d    = req_write;
        addr_d  = req_addr;
        wdata_d = req_wdata;
      end
      S_TURN_OUT: begin
        state_d = S_SETUP;
        cnt_d   = C_SETUP_LAST;
      end
      S_SETUP: if (cnt_q == 4'd0) begin
        state_d = S_STROBE;
        cnt_d   = C_STROBE_LAST;
      end else cnt_d = cnt_q - 4'd1;
      S_STROBE: if (cnt_q == 4'd0) begin
        state_d = S_HOLD;
        cnt_d   = C_HOLD_LAST;
        if (!wr_q) rbuf_d = pd_in;  // edge closing the last strobe cycle
      end else cnt_d = cnt_q - 4'd1;
      S_HOLD: if (cnt_q == 4'd0) state_d = S_TURN_IN;
              else cnt_d = cnt_q - 4'd1;
      S_TURN_IN: state_d = S_TURN_OUT == S_TURN_OUT ? S_RELEASE : S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so pins line up with the state register.
  always_comb begin
    w_drive      = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    w_span       = w_drive || (state_d == S_TURN_OUT) || (state_d == S_TURN_IN);
    pard_n_d     = !((state_d == S_STROBE) && !wr_d);
    pawr_n_d     = !((state_d == S_STROBE) && wr_d);
    lvl_pa_dir_d = w_span ? LVL_DIR_OUTPUT : LVL_DIR_INPUT;
    pa_dir_d     = w_drive ? DIR_OUTPUT : DIR_INPUT;
`ifdef BBUS_MASTER_KEEP_PA_EN
    if (lvl_pa_dir_q == LVL_DIR_OUTPUT) lvl_pa_dir_d = LVL_DIR_OUTPUT;
    if (pa_dir_q == DIR_OUTPUT) pa_dir_d = DIR_OUTPUT;
`endif
    pa_out_d     = w_drive ? addr_d : ((pa_dir_d == DIR_OUTPUT) ? pa_out_q : 8'h00);
    lvl_pd_dir_d = (w_span && wr_d) ? LVL_DIR_OUTPUT : LVL_DIR_INPUT;
    pd_dir_d     = (w_drive && wr_d) ? DIR_OUTPUT : DIR_INPUT;
    pd_out_d     = (w_drive && wr_d) ? wdata_d : 8'h00;
    rsp_valid_d  = (state_d == S_RELEASE);
    rsp_rdata_d  = ((state_d == S_RELEASE) && !wr_d) ? rbuf_q : rsp_rdata_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      wr_q         <= 1'b0;
      addr_q       <= 8'h00;
      wdata_q      <= 8'h00;
      rbuf_q       <= 8'h00;
      pard_n_q     <= 1'b1;
      pawr_n_q     <= 1'b1;
      lvl_pa_dir_q <= LVL_DIR_INPUT;
      lvl_pd_dir_q <= LVL_DIR_INPUT;
      pa_dir_q     <= DIR_INPUT;
      pd_dir_q     <= DIR_INPUT;
      pa_out_q     <= 8'h00;
      pd_out_q     <= 8'h00;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rbuf_q       <= rbuf_d;
      pard_n_q     <= pard_n_d;
      pawr_n_q     <= pawr_n_d;
      lvl_pa_dir_q <= lvl_pa_dir_d;
      lvl_pd_dir_q <= lvl_pd_dir_d;
      pa_dir_q     <= pa_dir_d;
      pd_dir_q     <= pd_dir_d;
      pa_out_q     <= pa_out_d;
      pd_out_q     <= pd_out_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE) && !reset;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign pard_n     = pard_n_q;
  assign pawr_n     = pawr_n_q;
  assign lvl_pa_dir = lvl_pa_dir_q;
  assign lvl_pd_dir = lvl_pd_dir_q;
  assign pa_dir     = pa_dir_q;
  assign pd_dir     = pd_dir_q;
  assign pa_out     = pa_out_q;
  assign pd_out     = pd_out_q;

endmodule
`default_nettype wire
